// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the two-entry skid pipeline register: state encodings,
// main-register load selector and the NOP word used as the reset payload.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        PSKID_EMPTY = 2'd0,
        PSKID_BUSY  = 2'd1,
        PSKID_FULL  = 2'd2
    } pskid_state_t;

    typedef enum logic [1:0] {
        MAIN_HOLD = 2'd0,
        MAIN_IN   = 2'd1,
        MAIN_SKID = 2'd2
    } main_sel_t;

    localparam logic [31:0] PSKID_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_reg.sv
// Handshaked pipeline register with a one-word skid so in_ready is a flop.
// Optional synchronous flush port is enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] set_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
`ifdef PIPE_SKID_FLUSH_EN
    ,
    input  logic          flush
`endif
);

    pskid_state_t  state_q;
    pskid_state_t  state_d;
    main_sel_t     main_sel;
    logic          skid_load;
    logic          in_ready_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          in_fire;
    logic          out_fire;

    assign out_valid = (state_q == PSKID_BUSY) || (state_q == PSKID_FULL);
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        main_sel  = MAIN_HOLD;
        skid_load = 1'b0;
        case (state_q)
            PSKID_EMPTY: begin
                if (in_fire) begin
                    main_sel = MAIN_IN;
                    state_d  = PSKID_BUSY;
                end
            end
            PSKID_BUSY: begin
                if (in_fire && out_fire) begin
                    main_sel = MAIN_IN;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = PSKID_FULL;
                end else if (out_fire) begin
                    state_d = PSKID_EMPTY;
                end
            end
            PSKID_FULL: begin
                // in_ready is low here, so only the downstream side can move.
                if (out_fire) begin
                    main_sel = MAIN_SKID;
                    state_d  = PSKID_BUSY;
                end
            end
            default: state_d = PSKID_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PSKID_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= set_data;
            skid_q     <= set_data;
`ifdef PIPE_SKID_FLUSH_EN
        end else if (flush) begin
            state_q    <= PSKID_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= set_data;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != PSKID_FULL);
            case (main_sel)
                MAIN_IN:   main_q <= in_data;
                MAIN_SKID: main_q <= skid_q;
                default:   main_q <= main_q;
            endcase
            if (skid_load) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random stalls,
// compared each cycle against a two-deep FIFO reference model.
module tb_pipe_skid_reg;

    localparam int DW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] set_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef PIPE_SKID_FLUSH_EN
    logic          flush = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of capacity two plus the last word handed out.
    logic [31:0] model_q[$];
    logic [31:0] model_last;

    pipe_skid_reg #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_data  (set_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_data;
        exp_data = (model_q.size() > 0) ? model_q[0] : model_last;
        check({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, model_q.size() > 0});
        check({tag, "_in_ready"},  {31'd0, in_ready},  {31'd0, model_q.size() < 2});
        check({tag, "_out_data"},  out_data, exp_data);
    endtask

    // Called at negedge: check, drive, clock once, advance model, return at negedge.
    task automatic step(input string tag, input logic iv, input logic [31:0] id, input logic ordy);
        bit in_f;
        bit out_f;
        check_model(tag);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        in_f  = iv && (model_q.size() < 2);
        out_f = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (out_f) model_last = model_q.pop_front();
        if (in_f) model_q.push_back(id);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (cycles) @(posedge clk);
        model_q.delete();
        model_last = set_data;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        set_data  = NOP;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_last = NOP;
        @(negedge clk);

        // Reset values
        do_reset(2);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        check("reset_out_data",  out_data, NOP);

        // Back-to-back streaming with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) step("stream", 1'b1, i, 1'b1);
        check("stream_last_word", out_data, 32'h8);
        step("stream_drain", 1'b0, 32'h0, 1'b1);
        check("stream_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure: A then B into a stalled output
        step("bp_a", 1'b1, 32'hA, 1'b0);
        step("bp_b", 1'b1, 32'hB, 1'b0);
        check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_full_holds_a",  out_data, 32'hA);
        step("bp_ignored", 1'b1, 32'hF00D, 1'b0);
        check("bp_still_a", out_data, 32'hA);
        step("bp_pop_a", 1'b0, 32'h0, 1'b1);
        check("bp_then_b",      out_data, 32'hB);
        check("bp_ready_again", {31'd0, in_ready}, 32'd1);
        step("bp_pop_b", 1'b0, 32'h0, 1'b1);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Random valid/ready traffic against the model
        for (int i = 0; i < 1000; i++) begin
            step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) step("rand_drain", 1'b0, 32'h0, 1'b1);

        // Reset while FULL holding C and D
        step("mid_c", 1'b1, 32'hC, 1'b0);
        step("mid_d", 1'b1, 32'hD, 1'b0);
        check("mid_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        do_reset(1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_data",  out_data, NOP);
        for (int i = 0; i < 3; i++) step("mid_after", 1'b0, 32'h0, 1'b1);

`ifdef PIPE_SKID_FLUSH_EN
        // Flush while BUSY drops the concurrent input word
        step("fl_load", 1'b1, 32'h55, 1'b0);
        check("fl_busy", {31'd0, out_valid}, 32'd1);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hE;
        out_ready = 1'b0;
        @(posedge clk);
        model_q.delete();
        model_last = set_data;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_out_data",  out_data, NOP);
        for (int i = 0; i < 3; i++) step("fl_after", 1'b0, 32'h0, 1'b1);
`endif

        check_model("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
